// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-port program/data memory between the CPU and the loader/debug port.
// Optional macro ARB_STARVE_EN adds a forced loader grant after WAIT_MAX contended cycles.
module mem_port_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int MAXBURST = 4,
    parameter int WAIT_MAX = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          CpuReq,
    input  logic          CpuWr,
    input  logic [AW-1:0] CpuAddr,
    input  logic [DW-1:0] CpuWData,
    output logic          CpuStall,
    input  logic          LdrReq,
    input  logic          LdrWr,
    input  logic [AW-1:0] LdrAddr,
    input  logic [DW-1:0] LdrWData,
    output logic          LdrAck,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    output logic          MemWr,
    input  logic [DW-1:0] MemRData,
    output logic          Owner,
    output logic [1:0]    ArbState
);

    typedef enum logic [1:0] {
        S_CPU = 2'b00,
        S_LDR = 2'b01
    } arbState_t;

    localparam int BW = $clog2(MAXBURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAXBURST - 1);

    if (MAXBURST < 1 || WAIT_MAX < 1) begin : gBadParams
        $error("mem_port_arbiter: MAXBURST and WAIT_MAX must be >= 1");
    end

    arbState_t     state;
    logic [BW-1:0] burstCnt;

`ifdef ARB_STARVE_EN
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);
    localparam logic [WW-1:0] WAIT_TOP  = WW'(WAIT_MAX);

    logic [WW-1:0] waitCnt;
`endif

    // Owner is registered alongside the state so the port mux never glitches on request inputs.
    // burstCnt saturates, so a long uncontended burst is cut right after CpuReq appears.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_CPU;
            Owner    <= 1'b0;
            burstCnt <= '0;
`ifdef ARB_STARVE_EN
            waitCnt  <= '0;
`endif
        end else begin
            case (state)
                S_CPU: begin
                    if (LdrReq && !CpuReq) begin
                        state    <= S_LDR;
                        Owner    <= 1'b1;
                        burstCnt <= '0;
`ifdef ARB_STARVE_EN
                        waitCnt  <= '0;
                    end else if (LdrReq && CpuReq) begin
                        if (waitCnt == WAIT_LAST) begin
                            state    <= S_LDR;
                            Owner    <= 1'b1;
                            burstCnt <= '0;
                            waitCnt  <= '0;
                        end else if (waitCnt != WAIT_TOP) begin
                            waitCnt <= waitCnt + WW'(1);
                        end
                    end else begin
                        waitCnt <= '0;
`endif
                    end
                end
                S_LDR: begin
                    if (!LdrReq || (CpuReq && burstCnt == BURST_LAST)) begin
                        state    <= S_CPU;
                        Owner    <= 1'b0;
                        burstCnt <= '0;
`ifdef ARB_STARVE_EN
                        waitCnt  <= '0;
`endif
                    end else if (burstCnt != BURST_LAST) begin
                        burstCnt <= burstCnt + BW'(1);
                    end
                end
                default: begin
                    state    <= S_CPU;
                    Owner    <= 1'b0;
                    burstCnt <= '0;
`ifdef ARB_STARVE_EN
                    waitCnt  <= '0;
`endif
                end
            endcase
        end
    end

    // Write enable is masked by Reset so an access caught by reset never lands in memory.
    assign MemAddr  = Owner ? LdrAddr  : CpuAddr;
    assign MemWData = Owner ? LdrWData : CpuWData;
    assign MemWr    = (Owner ? (LdrReq & LdrWr) : (CpuReq & CpuWr)) & ~Reset;
    assign CpuStall = CpuReq & Owner;
    assign LdrAck   = Owner & LdrReq;
    assign ArbState = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a request/grant-count model and a reference memory.
module tb_mem_port_arbiter;

    localparam int AW       = 5;
    localparam int DW       = 8;
    localparam int MAXBURST = 4;
    localparam int WAIT_MAX = 8;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          CpuReq;
    logic          CpuWr;
    logic [AW-1:0] CpuAddr;
    logic [DW-1:0] CpuWData;
    logic          CpuStall;
    logic          LdrReq;
    logic          LdrWr;
    logic [AW-1:0] LdrAddr;
    logic [DW-1:0] LdrWData;
    logic          LdrAck;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWData;
    logic          MemWr;
    logic [DW-1:0] MemRData;
    logic          Owner;
    logic [1:0]    ArbState;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAXBURST(MAXBURST), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .CpuReq(CpuReq), .CpuWr(CpuWr), .CpuAddr(CpuAddr), .CpuWData(CpuWData), .CpuStall(CpuStall),
        .LdrReq(LdrReq), .LdrWr(LdrWr), .LdrAddr(LdrAddr), .LdrWData(LdrWData), .LdrAck(LdrAck),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemWr(MemWr), .MemRData(MemRData),
        .Owner(Owner), .ArbState(ArbState)
    );

    always #5 Clock = ~Clock;

    // Memory array behind the port, with asynchronous read.
    logic          memClear;
    logic [DW-1:0] memArr [32];

    always @(posedge Clock) begin
        if (memClear) begin
            for (int i = 0; i < 32; i++) memArr[i] <= '0;
        end else if (MemWr) begin
            memArr[MemAddr] <= MemWData;
        end
    end

    assign MemRData = memArr[MemAddr];

    int total = 0;
    int bad   = 0;
    bit checkEn = 0;

    // Reference: who owns the port and how many loader accesses this grant has had.
    bit            mOwn  = 0;
    int            mAcks = 0;
`ifdef ARB_STARVE_EN
    int            mWait = 0;
`endif
    logic [DW-1:0] refMem [32];

    logic          eWr;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eWData;

    logic          sAck, sStall, sOwner, sMemWr;
    logic [1:0]    sState;
    logic [DW-1:0] sRData;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic cReq, input logic cWr,
                                 input logic [AW-1:0] cAddr, input logic [DW-1:0] cData,
                                 input logic lReq, input logic lWr,
                                 input logic [AW-1:0] lAddr, input logic [DW-1:0] lData);
        Reset    = rst;
        CpuReq   = cReq;
        CpuWr    = cWr;
        CpuAddr  = cAddr;
        CpuWData = cData;
        LdrReq   = lReq;
        LdrWr    = lWr;
        LdrAddr  = lAddr;
        LdrWData = lData;
    endtask

    task automatic checkOutput();
        eWr    = (mOwn ? (LdrReq && LdrWr) : (CpuReq && CpuWr)) && !Reset;
        eAddr  = mOwn ? LdrAddr : CpuAddr;
        eWData = mOwn ? LdrWData : CpuWData;
        sAck   = LdrAck;
        sStall = CpuStall;
        sOwner = Owner;
        sMemWr = MemWr;
        sState = ArbState;
        sRData = MemRData;
        if (checkEn) begin
            checkVal("owner", Owner, mOwn);
            checkVal("arbState", ArbState, mOwn ? 2'b01 : 2'b00);
            checkVal("cpuStall", CpuStall, CpuReq && mOwn);
            checkVal("ldrAck", LdrAck, LdrReq && mOwn);
            checkVal("memWr", MemWr, eWr);
            checkVal("memAddr", MemAddr, eAddr);
            checkVal("memWData", MemWData, eWData);
            if (mOwn && LdrReq && !LdrWr)
                checkVal("ldrRData", MemRData, refMem[LdrAddr]);
            if (!mOwn && CpuReq && !CpuWr)
                checkVal("cpuRData", MemRData, refMem[CpuAddr]);
        end
    endtask

    task automatic modelStep();
        if (eWr) refMem[eAddr] = eWData;
        if (Reset) begin
            mOwn  = 0;
            mAcks = 0;
`ifdef ARB_STARVE_EN
            mWait = 0;
`endif
        end else if (!mOwn) begin
            if (LdrReq && !CpuReq) begin
                mOwn  = 1;
                mAcks = 0;
`ifdef ARB_STARVE_EN
                mWait = 0;
            end else if (LdrReq) begin
                mWait++;
                if (mWait >= WAIT_MAX) begin
                    mOwn  = 1;
                    mAcks = 0;
                    mWait = 0;
                end
            end else begin
                mWait = 0;
`endif
            end
        end else begin
            if (!LdrReq) begin
                mOwn = 0;
            end else begin
                mAcks++;
                if (CpuReq && mAcks >= MAXBURST) mOwn = 0;
            end
`ifdef ARB_STARVE_EN
            if (!mOwn) mWait = 0;
`endif
        end
    endtask

    task automatic doCycle();
        #2;
        checkOutput();
        modelStep();
        @(negedge Clock);
    endtask

    initial begin
        int acks;
        int stalls;
        bit ldrPend;
        logic          rLdrWr;
        logic [AW-1:0] rLdrAddr;
        logic [DW-1:0] rLdrData;
        int cpuPct;

        for (int i = 0; i < 32; i++) refMem[i] = '0;
        memClear = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clock);
        doCycle();
        doCycle();
        memClear = 1'b0;
        checkEn  = 1;

        // Loader burst with idle CPU: writes then reads back.
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'd5, 8'h11);
        doCycle(); checkVal("ldrLatency", sAck, 0);
        doCycle(); checkVal("wrAck5", sAck, 1); checkVal("wrPulse5", sMemWr, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'd6, 8'h22);
        doCycle(); checkVal("wrAck6", sAck, 1); checkVal("wrPulse6", sMemWr, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'd7, 8'h33);
        doCycle(); checkVal("wrAck7", sAck, 1); checkVal("wrPulse7", sMemWr, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 5'd5, 8'h00);
        doCycle(); checkVal("rd5", sRData, 8'h11);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 5'd6, 8'h00);
        doCycle(); checkVal("rd6", sRData, 8'h22);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 5'd7, 8'h00);
        doCycle(); checkVal("rd7", sRData, 8'h33);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        doCycle(); checkVal("ldrDropAck", sAck, 0);

        // Reset held two cycles in the middle of traffic.
        applyStimulus(0, 1, 1, 5'd3, 8'h3C, 1, 0, 5'd9, 8'h00);
        doCycle();
        applyStimulus(1, 1, 1, 5'd4, 8'hC3, 1, 1, 5'd9, 8'h99);
        doCycle(); checkVal("rstWr0", sMemWr, 0);
        doCycle(); checkVal("rstWr1", sMemWr, 0);
        applyStimulus(0, 1, 0, 5'd3, 8'h00, 1, 1, 5'd9, 8'h99);
        doCycle();
        checkVal("postRstOwner", sOwner, 0);
        checkVal("postRstState", sState, 2'b00);
        checkVal("postRstStall", sStall, 0);
        checkVal("postRstAck", sAck, 0);
        checkVal("postRstMemWr", sMemWr, 0);
        checkVal("cpuRd3", sRData, 8'h3C);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        doCycle();

`ifndef ARB_STARVE_EN
        // Strict CPU priority: a busy CPU keeps the loader out indefinitely.
        acks = 0; stalls = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 0, 5'($urandom), 8'h00, 1, 1, 5'd12, 8'h5A);
            doCycle();
            acks += int'(sAck); stalls += int'(sStall);
        end
        checkVal("prioAcks", acks, 0);
        checkVal("prioStalls", stalls, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'd12, 8'h5A);
        doCycle(); checkVal("dropAck0", sAck, 0);
        doCycle(); checkVal("dropAck1", sAck, 1);
`else
        // Forced grant after WAIT_MAX contended cycles, for one MAXBURST burst.
        begin
            int preWait = 0;
            int own = 0;
            bit seenOwn = 0;
            acks = 0; stalls = 0;
            for (int i = 0; i < 14; i++) begin
                applyStimulus(0, 1, 0, 5'($urandom), 8'h00, 1, 0, 5'd12, 8'h00);
                doCycle();
                acks += int'(sAck);
                if (sOwner) begin
                    own++; stalls += int'(sStall); seenOwn = 1;
                end else if (!seenOwn) begin
                    preWait++;
                end
            end
            checkVal("starveWait", preWait, 8);
            checkVal("starveOwn", own, 4);
            checkVal("starveStalls", stalls, 4);
            checkVal("starveAcks", acks, 4);
        end
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        doCycle();

        // CpuReq rises during the 2nd loader access: burst is cut at MAXBURST.
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 5'd16, 8'h00);
        doCycle(); checkVal("cutAck0", sAck, 0);
        acks = 0;
        doCycle(); acks += int'(sAck);
        applyStimulus(0, 1, 0, 5'd2, 8'h00, 1, 0, 5'd16, 8'h00);
        doCycle(); checkVal("cutStall", sStall, 1); acks += int'(sAck);
        doCycle(); acks += int'(sAck);
        doCycle(); acks += int'(sAck);
        checkVal("cutAcks", acks, 4);
        doCycle(); checkVal("cutOwner", sOwner, 0); checkVal("cutNoStall", sStall, 0);
        acks = int'(sAck);
        for (int i = 0; i < 5; i++) begin
            doCycle(); acks += int'(sAck);
        end
        checkVal("cutHold", acks, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 5'd16, 8'h00);
        doCycle(); checkVal("resumeAck0", sAck, 0);
        doCycle(); checkVal("resumeAck1", sAck, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        doCycle();

        // Reset lands on a loader write: acked, not written, loader retries.
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'd20, 8'h77);
        doCycle();
        doCycle(); checkVal("burstWr20", sMemWr, 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 5'd21, 8'h88);
        doCycle(); checkVal("rstAck", sAck, 1); checkVal("rstWrSupp", sMemWr, 0);
        applyStimulus(0, 0, 0, 5'd21, 8'h00, 1, 1, 5'd21, 8'h88);
        doCycle(); checkVal("rstToCpu", sState, 2'b00); checkVal("word21Kept", sRData, 8'h00);
        doCycle(); checkVal("retryAck", sAck, 1); checkVal("retryWr", sMemWr, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        doCycle();

        // Randomized traffic with varying CPU load and occasional resets.
        ldrPend = 0; rLdrWr = 0; rLdrAddr = '0; rLdrData = '0;
        for (int i = 0; i < 1500; i++) begin
            cpuPct = ((i / 300) % 3 == 0) ? 10 : (((i / 300) % 3 == 1) ? 50 : 90);
            if (!ldrPend) begin
                ldrPend  = ($urandom_range(0, 2) != 0);
                rLdrWr   = 1'($urandom_range(0, 1));
                rLdrAddr = 5'($urandom);
                rLdrData = 8'($urandom);
            end
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 99) < cpuPct,
                          1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom),
                          ldrPend, rLdrWr, rLdrAddr, rLdrData);
            doCycle();
            if (sAck) ldrPend = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
